// File: rtl/bm_mac_pkg.sv
// rtl/bm_mac_pkg.sv - shared widths, Booth digit encoding and mode enum for the block-mantissa MAC
package bm_mac_pkg;

  localparam int DEF_MAN_W = 7;
  localparam int DEF_EXP_W = 2;
  localparam int DEF_ACC_W = 24;
  localparam int PROD_W    = 2 * DEF_MAN_W;
  localparam int SHIFT_MAX = 2 * ((1 << DEF_EXP_W) - 1);

  // One radix-4 Booth digit: magnitude select (one/two) plus negate.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

  localparam booth_sel_t BOOTH_ZERO = '{neg: 1'b0, one: 1'b0, two: 1'b0};
  localparam booth_sel_t BOOTH_P1   = '{neg: 1'b0, one: 1'b1, two: 1'b0};
  localparam booth_sel_t BOOTH_P2   = '{neg: 1'b0, one: 1'b0, two: 1'b1};
  localparam booth_sel_t BOOTH_M1   = '{neg: 1'b1, one: 1'b1, two: 1'b0};
  localparam booth_sel_t BOOTH_M2   = '{neg: 1'b1, one: 1'b0, two: 1'b1};

  typedef enum logic {
    MODE_FMA = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_sel_t booth_decode(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return BOOTH_P1;
      3'b011:         return BOOTH_P2;
      3'b100:         return BOOTH_M2;
      3'b101, 3'b110: return BOOTH_M1;
      default:        return BOOTH_ZERO;
    endcase
  endfunction

  function automatic int min_acc_w(input int man_w, input int exp_w);
    return 2 * man_w + 2 * ((1 << exp_w) - 1) + 1;
  endfunction

endpackage

// File: rtl/mbe_mul_signed.sv
// rtl/mbe_mul_signed.sv - radix-4 modified-Booth partial-product generator and reduction tree
// The two halves are independent so the parent can register the partial products between them.
module mbe_mul_signed
  import bm_mac_pkg::*;
#(
  parameter int MAN_W = DEF_MAN_W,
  parameter int PP_W  = 2 * MAN_W,
  parameter int NPP   = (MAN_W + 1) / 2
) (
  input  logic [MAN_W-1:0]    a,
  input  logic [MAN_W-1:0]    b,
  output logic [NPP*PP_W-1:0] pp,
  input  logic [NPP*PP_W-1:0] pp_q,
  output logic [PP_W-1:0]     prod
);

  localparam int BX_W = 2 * NPP + 1;

  logic [BX_W-1:0] b_ext;
  logic [PP_W-1:0] a_ext;
  logic [PP_W-1:0] mag;
  booth_sel_t      sel;

  // Each partial product is kept at full product width, pre-shifted to its digit weight,
  // so reduction is a plain modular sum.
  always_comb begin
    a_ext = PP_W'($signed(a));
    b_ext = BX_W'($signed({b, 1'b0}));
    mag   = '0;
    sel   = BOOTH_ZERO;
    pp    = '0;
    for (int i = 0; i < NPP; i++) begin
      sel = booth_decode(b_ext[2*i +: 3]);
      mag = sel.two ? (a_ext << 1) : (sel.one ? a_ext : '0);
      pp[i*PP_W +: PP_W] = (sel.neg ? -mag : mag) << (2 * i);
    end
  end

  always_comb begin
    prod = '0;
    for (int i = 0; i < NPP; i++) begin
      prod = prod + pp_q[i*PP_W +: PP_W];
    end
  end

endmodule

// File: rtl/bm_mac_pipe.sv
// rtl/bm_mac_pipe.sv - 3-stage block-mantissa MAC: a*b+c or running dot product with sticky overflow
// BM_MAC_SAT_EN defined: accumulator saturates and holds; otherwise it wraps.
module bm_mac_pipe
  import bm_mac_pkg::*;
#(
  parameter int MAN_W = DEF_MAN_W,
  parameter int EXP_W = DEF_EXP_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_last,
  input  logic [MAN_W-1:0] op_a_dat,
  input  logic [EXP_W-1:0] op_a_exp,
  input  logic [MAN_W-1:0] op_b_dat,
  input  logic [EXP_W-1:0] op_b_exp,
  input  logic [MAN_W-1:0] op_c_dat,
  input  logic [EXP_W-1:0] op_c_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] res,
  output logic             res_ovf
);

  localparam int PW   = 2 * MAN_W;
  localparam int NPP  = (MAN_W + 1) / 2;
  localparam int ES_W = EXP_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  generate
    if (ACC_W < min_acc_w(MAN_W, EXP_W)) begin : g_acc_w_too_small
      $error("bm_mac_pipe: ACC_W too small for MAN_W/EXP_W");
    end
  endgenerate

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  logic [NPP*PW-1:0] pp_comb;
  logic [PW-1:0]     prod_comb;

  logic              s1_valid;
  mode_e             s1_mode;
  logic              s1_last;
  logic [NPP*PW-1:0] s1_pp;
  logic [ES_W-1:0]   s1_esum;
  logic [ACC_W-1:0]  s1_c;

  logic              s2_valid;
  mode_e             s2_mode;
  logic              s2_last;
  logic [ACC_W-1:0]  s2_prod;
  logic [ACC_W-1:0]  s2_c;

  logic [ACC_W-1:0]  acc;
  logic              acc_ovf;

  mbe_mul_signed #(
    .MAN_W (MAN_W),
    .PP_W  (PW),
    .NPP   (NPP)
  ) u_mul (
    .a    (op_a_dat),
    .b    (op_b_dat),
    .pp   (pp_comb),
    .pp_q (s1_pp),
    .prod (prod_comb)
  );

  // S1: Booth partial products, exponent sum, aligned addend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_FMA;
      s1_last  <= 1'b0;
      s1_pp    <= '0;
      s1_esum  <= '0;
      s1_c     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= mode_e'(in_mode);
      s1_last  <= in_last & in_mode;
      s1_pp    <= pp_comb;
      s1_esum  <= ES_W'(op_a_exp) + ES_W'(op_b_exp);
      s1_c     <= ACC_W'($signed(op_c_dat)) << op_c_exp;
    end
  end

  // S2: reduced product, scaled by the exponent sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_mode  <= MODE_FMA;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
      s2_c     <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_last  <= s1_last;
      s2_prod  <= ACC_W'($signed(prod_comb)) << s1_esum;
      s2_c     <= s1_c;
    end
  end

  logic [ACC_W-1:0] fma_sum;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             add_ovf;
  logic             ovf_next;

  always_comb begin
    fma_sum = s2_prod + s2_c;
    acc_sum = acc + s2_prod;
    add_ovf = (acc[ACC_W-1] == s2_prod[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef BM_MAC_SAT_EN
    // Once clamped, the accumulator stays pinned until the sequence closes.
    if (acc_ovf) begin
      acc_next = acc;
    end else if (add_ovf) begin
      acc_next = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = acc_sum;
    end
`else
    acc_next = acc_sum;
`endif
    ovf_next = acc_ovf | add_ovf;
  end

  // S3: result register and accumulator; FMA beats leave the accumulator untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      res_ovf   <= 1'b0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (s2_valid) begin
        if (s2_mode == MODE_FMA) begin
          out_valid <= 1'b1;
          res       <= fma_sum;
          res_ovf   <= 1'b0;
        end else if (s2_last) begin
          out_valid <= 1'b1;
          res       <= acc_next;
          res_ovf   <= ovf_next;
          acc       <= '0;
          acc_ovf   <= 1'b0;
        end else begin
          acc       <= acc_next;
          acc_ovf   <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_bm_mac_pipe.sv
// tb/tb_bm_mac_pipe.sv - directed self-checking bench for bm_mac_pipe
module tb_bm_mac_pipe;

  localparam int MAN_W = 7;
  localparam int EXP_W = 2;
  localparam int ACC_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic             in_last;
  logic [MAN_W-1:0] op_a_dat;
  logic [EXP_W-1:0] op_a_exp;
  logic [MAN_W-1:0] op_b_dat;
  logic [EXP_W-1:0] op_b_exp;
  logic [MAN_W-1:0] op_c_dat;
  logic [EXP_W-1:0] op_c_exp;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] res;
  logic             res_ovf;

  int errors = 0;
  int checks = 0;
  int q[$];

  bm_mac_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .op_a_dat  (op_a_dat),
    .op_a_exp  (op_a_exp),
    .op_b_dat  (op_b_dat),
    .op_b_exp  (op_b_exp),
    .op_c_dat  (op_c_dat),
    .op_c_exp  (op_c_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic l, input int a, input int ea,
                       input int b, input int eb, input int c, input int ec);
    in_valid = 1'b1;
    in_mode  = m;
    in_last  = l;
    op_a_dat = a[MAN_W-1:0];
    op_a_exp = ea[EXP_W-1:0];
    op_b_dat = b[MAN_W-1:0];
    op_b_exp = eb[EXP_W-1:0];
    op_c_dat = c[MAN_W-1:0];
    op_c_exp = ec[EXP_W-1:0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_mode  = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits (bounded) for a result, checks it, then lets the next edge consume it.
  task automatic get_result(input string tag, input int exp_res, input logic exp_ovf);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      step();
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"}, $signed(res), exp_res);
    check({tag, "_ovf"}, res_ovf, exp_ovf);
    step();
  endtask

  initial begin
    int a, b, c, ea, eb, ec;
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    op_a_dat = '0; op_a_exp = '0; op_b_dat = '0; op_b_exp = '0; op_c_dat = '0; op_c_exp = '0;
    step(); step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_res", $signed(res), 0);
    check("rst_res_ovf", res_ovf, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);

    // Extreme operands, latency of exactly three edges.
    drive(1'b0, 1'b0, -64, 3, -64, 3, 63, 3);
    step();
    idle();
    check("lat_edge1", out_valid, 0);
    step();
    check("lat_edge2", out_valid, 0);
    step();
    check("lat_edge3", out_valid, 1);
    get_result("extreme", 262648, 1'b0);
    check("extreme_single", out_valid, 0);

    drive(1'b0, 1'b0, 63, 0, -64, 0, -64, 0);
    step();
    idle();
    get_result("fma_neg", -4096, 1'b0);

    drive(1'b0, 1'b0, 3, 1, -5, 2, -7, 2);
    step();
    idle();
    get_result("fma_exp", -148, 1'b0);

    // Four-beat dot product, one result only.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i == 4, i, 0, 2, 0, 9, 0);
      step();
    end
    idle();
    get_result("dot4", 20, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("dot4_no_extra", out_valid, 0);
    end
    drive(1'b1, 1'b1, 5, 0, 3, 0, 0, 0);
    step();
    idle();
    get_result("dot_restart", 15, 1'b0);

    // FMA interleaved inside an open accumulation.
    drive(1'b1, 1'b0, 2, 0, 3, 0, 0, 0);
    step();
    drive(1'b0, 1'b1, 1, 0, 1, 0, 1, 0);
    step();
    drive(1'b1, 1'b1, 1, 0, 1, 0, 0, 0);
    step();
    idle();
    get_result("mixed_fma", 2, 1'b0);
    get_result("mixed_acc", 7, 1'b0);

    // Backpressure.
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1, 0, 1, 0, 0, 0);
    step();
    drive(1'b0, 1'b0, 2, 0, 3, 0, 1, 0);
    step();
    drive(1'b0, 1'b0, -4, 0, 5, 0, 0, 0);
    step();
    idle();
    check("bp_valid", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_res", $signed(res), 1);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    get_result("bp_r0", 1, 1'b0);
    get_result("bp_r1", 7, 1'b0);
    get_result("bp_r2", -20, 1'b0);

    // Accumulator overflow, then a clean sequence.
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, i == 40, -64, 3, -64, 3, 0, 0);
      step();
    end
    idle();
`ifdef BM_MAC_SAT_EN
    get_result("ovf40", 8388607, 1'b1);
`else
    get_result("ovf40", -6291456, 1'b1);
`endif
    drive(1'b1, 1'b1, 1, 0, 1, 0, 0, 0);
    step();
    idle();
    get_result("ovf_cleared", 1, 1'b0);

    // Reset with beats in flight.
    drive(1'b1, 1'b0, 10, 0, 10, 0, 0, 0);
    step();
    drive(1'b0, 1'b0, 1, 0, 1, 0, 5, 0);
    step();
    drive(1'b0, 1'b0, 2, 0, 2, 0, 0, 0);
    step();
    idle();
    step();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_res", $signed(res), 6);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_res", $signed(res), 0);
    check("async_rst_ready", in_ready, 1);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_flushed", out_valid, 0);
    end
    drive(1'b1, 1'b1, 1, 0, 1, 0, 0, 0);
    step();
    idle();
    get_result("post_rst_acc", 1, 1'b0);
    drive(1'b0, 1'b0, 63, 0, -64, 0, -64, 0);
    step();
    idle();
    get_result("post_rst_fma", -4096, 1'b0);

    // Streaming MODE 0 sweep against an integer model.
    for (int i = 0; i < 200; i++) begin
      if (i < 4) begin
        a = (i & 1) ? 63 : -64;
        b = (i & 2) ? 63 : -64;
        c = -64;
        ea = 3; eb = 3; ec = 3;
      end else begin
        a = int'($urandom_range(0, 127)) - 64;
        b = int'($urandom_range(0, 127)) - 64;
        c = int'($urandom_range(0, 127)) - 64;
        ea = int'($urandom_range(0, 3));
        eb = int'($urandom_range(0, 3));
        ec = int'($urandom_range(0, 3));
      end
      drive(1'b0, 1'b1, a, ea, b, eb, c, ec);
      q.push_back((a * (1 << ea)) * (b * (1 << eb)) + c * (1 << ec));
      step();
      if (out_valid) begin
        if (q.size() > 1) check("sweep", $signed(res), q.pop_front());
        else check("sweep_unexpected", out_valid, 0);
      end
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) begin
        if (q.size() > 0) check("sweep", $signed(res), q.pop_front());
        else check("sweep_unexpected", out_valid, 0);
      end
    end
    check("sweep_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
